// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl
// Description : Main control FSM for the shared-resource multicycle MIPS-subset
//               datapath. A single memory serves instruction and data, and a
//               single ALU serves PC increment, branch target and execution.
//               The FSM decodes op/funct from the IR and drives the per-cycle
//               mux selects, write enables and the ALU op class.
//
// Parameters  : TRAP_STICKY - 1: an illegal opcode parks the FSM in TRAP until
//                                reset; 0: TRAP returns to FETCH next cycle.
// Macro       : MEM_WAIT_EN - when defined, FETCH / MEM_READ / MEM_WRITE hold
//                             until mem_ready_i is high. Undefined: every memory
//                             state takes exactly one cycle.
//
// Ports       : clk_i           clock, rising edge
//               rst_i           asynchronous active-low reset
//               op_i[5:0]       IR[31:26]
//               funct_i[5:0]    IR[5:0]
//               mem_ready_i     memory done (MEM_WAIT_EN builds only)
//               pc_write_o      unconditional PC load
//               pc_write_cond_o PC load if branch condition true
//               branch_ne_o     0 = load on zero, 1 = load on ~zero
//               i_or_d_o        memory address: 0 = PC, 1 = ALUOut
//               mem_read_o      memory read strobe
//               mem_write_o     memory write strobe
//               ir_write_o      IR load
//               wb_sel_o[1:0]   RF write data: 00 ALUOut, 01 MDR, 10 PC
//               reg_dst_o[1:0]  RF write address: 00 rt, 01 rd, 10 r31
//               reg_write_o     RF write enable
//               alu_src_a_o     0 = PC, 1 = A register
//               alu_src_b_o     00 B, 01 const 4, 10 imm, 11 imm<<2
//               alu_op_o[1:0]   00 add, 01 sub, 10 funct-decoded
//               pc_source_o     00 ALU, 01 ALUOut, 10 jump tgt, 11 A (jr)
//               instr_done_o    1-cycle pulse in final state of instruction
//               illegal_o       high in TRAP
//               state_o[3:0]    current state encoding
//
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
    parameter bit TRAP_STICKY = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    input  logic       mem_ready_i,
    output logic       pc_write_o,
    output logic       pc_write_cond_o,
    output logic       branch_ne_o,
    output logic       i_or_d_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       ir_write_o,
    output logic [1:0] wb_sel_o,
    output logic [1:0] reg_dst_o,
    output logic       reg_write_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] alu_op_o,
    output logic [1:0] pc_source_o,
    output logic       instr_done_o,
    output logic       illegal_o,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_ADDI_EX   = 4'd9,
        S_ADDI_WB   = 4'd10,
        S_JUMP      = 4'd11,
        S_JAL       = 4'd12,
        S_JR        = 4'd13,
        S_TRAP      = 4'd14,
        S_UNUSED    = 4'd15
    } state_e;

    localparam logic [5:0] C_OP_RTYPE = 6'h00;
    localparam logic [5:0] C_OP_J     = 6'h02;
    localparam logic [5:0] C_OP_JAL   = 6'h03;
    localparam logic [5:0] C_OP_BEQ   = 6'h04;
    localparam logic [5:0] C_OP_BNE   = 6'h05;
    localparam logic [5:0] C_OP_ADDI  = 6'h08;
    localparam logic [5:0] C_OP_LW    = 6'h23;
    localparam logic [5:0] C_OP_SW    = 6'h2B;
    localparam logic [5:0] C_FN_JR    = 6'h08;

    state_e state_q;
    state_e state_d;

    // Memory handshake: without the wait feature the memory is assumed to
    // complete every access in one cycle.
    logic w_mem_rdy;
`ifdef MEM_WAIT_EN
    assign w_mem_rdy = mem_ready_i;
`else
    logic w_mem_ready_unused;
    assign w_mem_ready_unused = mem_ready_i;
    assign w_mem_rdy          = 1'b1;
`endif

    // Raw Moore decode (before the reset gate)
    logic       w_pc_write;
    logic       w_pc_write_cond;
    logic       w_branch_ne;
    logic       w_i_or_d;
    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_ir_write;
    logic [1:0] w_wb_sel;
    logic [1:0] w_reg_dst;
    logic       w_reg_write;
    logic       w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_alu_op;
    logic [1:0] w_pc_source;
    logic       w_done;
    logic       w_illegal;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------------
    always_comb begin
        state_d         = state_q;
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        w_branch_ne     = 1'b0;
        w_i_or_d        = 1'b0;
        w_mem_read      = 1'b0;
        w_mem_write     = 1'b0;
        w_ir_write      = 1'b0;
        w_wb_sel        = 2'b00;
        w_reg_dst       = 2'b00;
        w_reg_write     = 1'b0;
        w_alu_src_a     = 1'b0;
        w_alu_src_b     = 2'b00;
        w_alu_op        = 2'b00;
        w_pc_source     = 2'b00;
        w_done          = 1'b0;
        w_illegal       = 1'b0;

        case (state_q)
            S_FETCH: begin
                // The read strobe is held for the whole access; the IR and
                // PC only commit in the cycle the memory completes.
                w_mem_read  = 1'b1;
                w_alu_src_b = 2'b01;
                w_ir_write  = w_mem_rdy;
                w_pc_write  = w_mem_rdy;
                state_d     = w_mem_rdy ? S_DECODE : S_FETCH;
            end

            S_DECODE: begin
                // Branch target (PC+4 + imm<<2) is precomputed into ALUOut here.
                w_alu_src_b = 2'b11;
                case (op_i)
                    C_OP_LW,
                    C_OP_SW:    state_d = S_MEM_ADDR;
                    C_OP_RTYPE: state_d = (funct_i == C_FN_JR) ? S_JR : S_EXECUTE;
                    C_OP_BEQ,
                    C_OP_BNE:   state_d = S_BRANCH;
                    C_OP_ADDI:  state_d = S_ADDI_EX;
                    C_OP_J:     state_d = S_JUMP;
                    C_OP_JAL:   state_d = S_JAL;
                    default:    state_d = S_TRAP;
                endcase
            end

            S_MEM_ADDR: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
                state_d     = (op_i == C_OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end

            S_MEM_READ: begin
                w_mem_read = 1'b1;
                w_i_or_d   = 1'b1;
                state_d    = w_mem_rdy ? S_MEM_WB : S_MEM_READ;
            end

            S_MEM_WB: begin
                w_reg_write = 1'b1;
                w_wb_sel    = 2'b01;
                w_reg_dst   = 2'b00;
                w_done      = 1'b1;
                state_d     = S_FETCH;
            end

            S_MEM_WRITE: begin
                w_mem_write = 1'b1;
                w_i_or_d    = 1'b1;
                w_done      = w_mem_rdy;
                state_d     = w_mem_rdy ? S_FETCH : S_MEM_WRITE;
            end

            S_EXECUTE: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = 2'b10;
                state_d     = S_R_WB;
            end

            S_R_WB: begin
                w_reg_write = 1'b1;
                w_reg_dst   = 2'b01;
                w_done      = 1'b1;
                state_d     = S_FETCH;
            end

            S_BRANCH: begin
                // ALU compares A-B; the datapath qualifies pc_write_cond with
                // the zero flag in the polarity selected by branch_ne.
                w_alu_src_a     = 1'b1;
                w_alu_op        = 2'b01;
                w_pc_write_cond = 1'b1;
                w_pc_source     = 2'b01;
                w_branch_ne     = (op_i == C_OP_BNE);
                w_done          = 1'b1;
                state_d         = S_FETCH;
            end

            S_ADDI_EX: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
                state_d     = S_ADDI_WB;
            end

            S_ADDI_WB: begin
                w_reg_write = 1'b1;
                w_reg_dst   = 2'b00;
                w_done      = 1'b1;
                state_d     = S_FETCH;
            end

            S_JUMP: begin
                w_pc_write  = 1'b1;
                w_pc_source = 2'b10;
                w_done      = 1'b1;
                state_d     = S_FETCH;
            end

            S_JAL: begin
                // r31 receives the current PC, which already holds PC+4
                // since FETCH; the PC update lands on the same edge.
                w_pc_write  = 1'b1;
                w_pc_source = 2'b10;
                w_reg_write = 1'b1;
                w_reg_dst   = 2'b10;
                w_wb_sel    = 2'b10;
                w_done      = 1'b1;
                state_d     = S_FETCH;
            end

            S_JR: begin
                w_pc_write  = 1'b1;
                w_pc_source = 2'b11;
                w_done      = 1'b1;
                state_d     = S_FETCH;
            end

            S_TRAP: begin
                w_illegal = 1'b1;
                state_d   = TRAP_STICKY ? S_TRAP : S_FETCH;
            end

            default: begin
                // Unreachable encoding: recover silently with all outputs low.
                state_d = S_FETCH;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output gate: while reset is held every output, including state_o, is
    // forced low combinationally so no strobe outlives reset assertion.
    // ------------------------------------------------------------------------
    always_comb begin
        pc_write_o      = rst_i & w_pc_write;
        pc_write_cond_o = rst_i & w_pc_write_cond;
        branch_ne_o     = rst_i & w_branch_ne;
        i_or_d_o        = rst_i & w_i_or_d;
        mem_read_o      = rst_i & w_mem_read;
        mem_write_o     = rst_i & w_mem_write;
        ir_write_o      = rst_i & w_ir_write;
        wb_sel_o        = {2{rst_i}} & w_wb_sel;
        reg_dst_o       = {2{rst_i}} & w_reg_dst;
        reg_write_o     = rst_i & w_reg_write;
        alu_src_a_o     = rst_i & w_alu_src_a;
        alu_src_b_o     = {2{rst_i}} & w_alu_src_b;
        alu_op_o        = {2{rst_i}} & w_alu_op;
        pc_source_o     = {2{rst_i}} & w_pc_source;
        instr_done_o    = rst_i & w_done;
        illegal_o       = rst_i & w_illegal;
        state_o         = {4{rst_i}} & state_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_ctrl
// Description : Self-checking bench for multicycle_ctrl. The driver pushes the
//               hand-derived expected output vector for each cycle into a
//               queue; the monitor pops and compares on every falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw;
        logic       pcwc;
        logic       bne;
        logic       iord;
        logic       mrd;
        logic       mwr;
        logic       irw;
        logic [1:0] wbs;
        logic [1:0] rdst;
        logic       rw;
        logic       asa;
        logic [1:0] asb;
        logic [1:0] aop;
        logic [1:0] psrc;
        logic       done;
        logic       ill;
    } ovec_t;

    logic       clk_i;
    logic       rst_i;
    logic [5:0] op_i;
    logic [5:0] funct_i;
    logic       mem_ready_i;
    logic       pc_write_o;
    logic       pc_write_cond_o;
    logic       branch_ne_o;
    logic       i_or_d_o;
    logic       mem_read_o;
    logic       mem_write_o;
    logic       ir_write_o;
    logic [1:0] wb_sel_o;
    logic [1:0] reg_dst_o;
    logic       reg_write_o;
    logic       alu_src_a_o;
    logic [1:0] alu_src_b_o;
    logic [1:0] alu_op_o;
    logic [1:0] pc_source_o;
    logic       instr_done_o;
    logic       illegal_o;
    logic [3:0] state_o;

    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    ovec_t exp_q[$];

    multicycle_ctrl #(.TRAP_STICKY(1'b1)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .op_i            (op_i),
        .funct_i         (funct_i),
        .mem_ready_i     (mem_ready_i),
        .pc_write_o      (pc_write_o),
        .pc_write_cond_o (pc_write_cond_o),
        .branch_ne_o     (branch_ne_o),
        .i_or_d_o        (i_or_d_o),
        .mem_read_o      (mem_read_o),
        .mem_write_o     (mem_write_o),
        .ir_write_o      (ir_write_o),
        .wb_sel_o        (wb_sel_o),
        .reg_dst_o       (reg_dst_o),
        .reg_write_o     (reg_write_o),
        .alu_src_a_o     (alu_src_a_o),
        .alu_src_b_o     (alu_src_b_o),
        .alu_op_o        (alu_op_o),
        .pc_source_o     (pc_source_o),
        .instr_done_o    (instr_done_o),
        .illegal_o       (illegal_o),
        .state_o         (state_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Expected outputs per state, transcribed from the state table.
    function automatic ovec_t exp_of(input logic [3:0] s, input logic [5:0] op,
                                     input logic rdy);
        ovec_t e;
        e    = '0;
        e.st = s;
        case (s)
            4'd0:  begin e.mrd = 1; e.asb = 2'b01; e.irw = rdy; e.pcw = rdy; end
            4'd1:  begin e.asb = 2'b11; end
            4'd2:  begin e.asa = 1; e.asb = 2'b10; end
            4'd3:  begin e.mrd = 1; e.iord = 1; end
            4'd4:  begin e.rw = 1; e.wbs = 2'b01; e.done = 1; end
            4'd5:  begin e.mwr = 1; e.iord = 1; e.done = rdy; end
            4'd6:  begin e.asa = 1; e.aop = 2'b10; end
            4'd7:  begin e.rw = 1; e.rdst = 2'b01; e.done = 1; end
            4'd8:  begin e.asa = 1; e.aop = 2'b01; e.pcwc = 1; e.psrc = 2'b01;
                         e.bne = (op == 6'h05); e.done = 1; end
            4'd9:  begin e.asa = 1; e.asb = 2'b10; end
            4'd10: begin e.rw = 1; e.done = 1; end
            4'd11: begin e.pcw = 1; e.psrc = 2'b10; e.done = 1; end
            4'd12: begin e.pcw = 1; e.psrc = 2'b10; e.rw = 1; e.rdst = 2'b10;
                         e.wbs = 2'b10; e.done = 1; end
            4'd13: begin e.pcw = 1; e.psrc = 2'b11; e.done = 1; end
            4'd14: begin e.ill = 1; end
            default: e = '0;
        endcase
        return e;
    endfunction

    // One clock: inputs settle just after the rising edge, then the expected
    // vector for the state entered on that edge is queued.
    task automatic step(input logic [3:0] s, input logic rdy);
        @(posedge clk_i);
        #1;
        mem_ready_i = rdy;
        exp_q.push_back(exp_of(s, op_i, rdy));
    endtask

    task automatic step_reset();
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        exp_q.push_back('0);
    endtask

    // FETCH cycle with the new instruction presented, then the remaining states.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int n,
                             input logic [3:0] s1, input logic [3:0] s2,
                             input logic [3:0] s3, input logic [3:0] s4);
        @(posedge clk_i);
        #1;
        op_i        = op;
        funct_i     = fn;
        mem_ready_i = 1'b1;
        rst_i       = 1'b1;
        exp_q.push_back(exp_of(4'd0, op, 1'b1));
        if (n > 0) step(s1, 1'b1);
        if (n > 1) step(s2, 1'b1);
        if (n > 2) step(s3, 1'b1);
        if (n > 3) step(s4, 1'b1);
    endtask

    // Monitor: every falling edge with a pending expectation is one comparison.
    always @(negedge clk_i) begin
        ovec_t a;
        ovec_t e;
        cyc = cyc + 1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{st: state_o, pcw: pc_write_o, pcwc: pc_write_cond_o,
                  bne: branch_ne_o, iord: i_or_d_o, mrd: mem_read_o,
                  mwr: mem_write_o, irw: ir_write_o, wbs: wb_sel_o,
                  rdst: reg_dst_o, rw: reg_write_o, asa: alu_src_a_o,
                  asb: alu_src_b_o, aop: alu_op_o, psrc: pc_source_o,
                  done: instr_done_o, ill: illegal_o};
            total = total + 1;
            if (a !== e) begin
                bad = bad + 1;
                $display("FAIL outvec cyc=%0d exp_state=%0d actual=%h required=%h",
                         cyc, e.st, a, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst_i       = 1'b0;
        op_i        = 6'h00;
        funct_i     = 6'h00;
        mem_ready_i = 1'b1;

        // Reset held for 3 cycles: everything low.
        repeat (3) step_reset();

        // lw: release reset straight into FETCH, 5 cycles.
        run_instr(6'h23, 6'h00, 4, 4'd1, 4'd2, 4'd3, 4'd4);
        // sw: 4 cycles
        run_instr(6'h2B, 6'h00, 3, 4'd1, 4'd2, 4'd5, 4'd0);
        // R-type add: 4 cycles
        run_instr(6'h00, 6'h20, 3, 4'd1, 4'd6, 4'd7, 4'd0);
        // jr: 3 cycles
        run_instr(6'h00, 6'h08, 2, 4'd1, 4'd13, 4'd0, 4'd0);
        // bne then beq: branch polarity
        run_instr(6'h05, 6'h00, 2, 4'd1, 4'd8, 4'd0, 4'd0);
        run_instr(6'h04, 6'h00, 2, 4'd1, 4'd8, 4'd0, 4'd0);
        // addi: 4 cycles
        run_instr(6'h08, 6'h00, 3, 4'd1, 4'd9, 4'd10, 4'd0);
        // j, jal
        run_instr(6'h02, 6'h00, 2, 4'd1, 4'd11, 4'd0, 4'd0);
        run_instr(6'h03, 6'h00, 2, 4'd1, 4'd12, 4'd0, 4'd0);
        // Illegal opcode: parks in TRAP
        run_instr(6'h3F, 6'h00, 1, 4'd1, 4'd0, 4'd0, 4'd0);
        repeat (10) step(4'd14, 1'b1);
        // Reset recovers to FETCH
        repeat (2) step_reset();
        run_instr(6'h00, 6'h20, 3, 4'd1, 4'd6, 4'd7, 4'd0);

        // Async reset asserted as sw enters MEM_WRITE: strobe must vanish.
        run_instr(6'h2B, 6'h00, 2, 4'd1, 4'd2, 4'd0, 4'd0);
        step_reset();
        step_reset();
        run_instr(6'h23, 6'h00, 4, 4'd1, 4'd2, 4'd3, 4'd4);

`ifdef MEM_WAIT_EN
        // sw with three wait cycles in MEM_WRITE
        run_instr(6'h2B, 6'h00, 2, 4'd1, 4'd2, 4'd0, 4'd0);
        repeat (3) step(4'd5, 1'b0);
        step(4'd5, 1'b1);
        // FETCH stall then lw with one MEM_READ wait
        @(posedge clk_i);
        #1;
        op_i        = 6'h23;
        mem_ready_i = 1'b0;
        exp_q.push_back(exp_of(4'd0, 6'h23, 1'b0));
        step(4'd0, 1'b1);
        step(4'd1, 1'b1);
        step(4'd2, 1'b0);
        step(4'd3, 1'b0);
        step(4'd3, 1'b1);
        step(4'd4, 1'b1);
        // Reset mid-wait
        run_instr(6'h2B, 6'h00, 2, 4'd1, 4'd2, 4'd0, 4'd0);
        step(4'd5, 1'b0);
        step_reset();
        run_instr(6'h08, 6'h00, 3, 4'd1, 4'd9, 4'd10, 4'd0);
`endif

        // Let the monitor drain the queue.
        repeat (3) @(negedge clk_i);
        #1;
        total = total + 1;
        if (exp_q.size() != 0) begin
            bad = bad + 1;
            $display("FAIL drain: pending=%0d required=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control FSM that sequences a shared-resource multicycle version of the MIPS-subset datapath.
- One memory serves both instruction and data; one ALU handles PC increment, branch target and execution.
- Decodes opcode/funct from the instruction register.
- Drives per-cycle mux selects, write enables and the ALU op class for the downstream ALU control.
- Replaces the single-cycle decoder; sits beside the datapath at top level.

Parameters:
TRAP_STICKY, 1, 1 = illegal opcode parks FSM in TRAP until reset; 0 = TRAP returns to FETCH next cycle.

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous active-low reset
op_i  in  6  IR[31:26], stable from DECODE until instruction end
funct_i  in  6  IR[5:0]
mem_ready_i  in  1  memory done (used only with MEM_WAIT_EN)
pc_write_o  out  1  unconditional PC load
pc_write_cond_o  out  1  PC load if branch condition true
branch_ne_o  out  1  condition polarity: 0 = load on zero, 1 = load on ~zero
i_or_d_o  out  1  memory address: 0 = PC, 1 = ALUOut
mem_read_o  out  1  memory read strobe
mem_write_o  out  1  memory write strobe
ir_write_o  out  1  IR load
wb_sel_o  out  2  RF write data: 00 ALUOut, 01 MDR, 10 PC
reg_dst_o  out  2  RF write address: 00 rt, 01 rd, 10 r31
reg_write_o  out  1  RF write enable
alu_src_a_o  out  1  0 = PC, 1 = A register
alu_src_b_o  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
alu_op_o  out  2  00 add, 01 sub, 10 funct-decoded
pc_source_o  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 A register (jr)
instr_done_o  out  1  1-cycle pulse in final state of each instruction
illegal_o  out  1  high in TRAP
state_o  out  4  current state encoding

Behaviour:
- Moore FSM: outputs decoded from state register only.
- While rst_i=0: state=FETCH(0) and all outputs forced to 0, including state_o. After release, FETCH outputs appear in the same cycle.
- Outputs not listed for a state are 0.
- States, encodings, asserted outputs and next state:
  - FETCH 0: mem_read, ir_write, pc_write, alu_src_b=01 -> DECODE.
  - DECODE 1: alu_src_b=11. Next state by op_i:
    - 0x23/0x2B -> MEM_ADDR
    - 0x00 with funct 0x08 -> JR; other 0x00 -> EXECUTE
    - 0x04/0x05 -> BRANCH
    - 0x08 -> ADDI_EX
    - 0x02 -> JUMP
    - 0x03 -> JAL
    - any other -> TRAP
  - MEM_ADDR 2: alu_src_a=1, alu_src_b=10 -> MEM_READ if op 0x23, else MEM_WRITE.
  - MEM_READ 3: mem_read, i_or_d=1 -> MEM_WB.
  - MEM_WB 4: reg_write, wb_sel=01, reg_dst=00, done -> FETCH.
  - MEM_WRITE 5: mem_write, i_or_d=1, done -> FETCH.
  - EXECUTE 6: alu_src_a=1, alu_op=10 -> R_WB.
  - R_WB 7: reg_write, reg_dst=01, done -> FETCH.
  - BRANCH 8: alu_src_a=1, alu_op=01, pc_write_cond, pc_source=01, branch_ne=(op_i==0x05), done -> FETCH.
  - ADDI_EX 9: alu_src_a=1, alu_src_b=10 -> ADDI_WB.
  - ADDI_WB 10: reg_write, reg_dst=00, done -> FETCH.
  - JUMP 11: pc_write, pc_source=10, done -> FETCH.
  - JAL 12: pc_write, pc_source=10, reg_write, reg_dst=10, wb_sel=10, done -> FETCH. The RF captures the pre-update PC (already PC+4).
  - JR 13: pc_write, pc_source=11, done -> FETCH.
  - TRAP 14: illegal_o=1. If TRAP_STICKY, hold; else -> FETCH. No pulse on instr_done_o.
- Encoding 15 is unreachable; if entered, go to FETCH next cycle with outputs 0.
- Cycle counts: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j/jal/jr 3.
- Async reset mid-instruction aborts it immediately; no partial write strobe survives past reset assertion.

Optional Feature:
MEM_WAIT_EN:
- Defined: FETCH, MEM_READ and MEM_WRITE hold while mem_ready_i=0. During wait cycles mem_read/mem_write/i_or_d stay asserted, and ir_write, pc_write and instr_done_o are suppressed. These assert only in the cycle mem_ready_i=1, then the state advances.
- Undefined: mem_ready_i is ignored and every memory state takes exactly one cycle.

Test Plan:
- Reset: hold rst_i=0 for 3 cycles -> all outputs 0. Release -> state_o=0, mem_read=ir_write=pc_write=1, alu_src_b=01.
- lw (op 0x23): state_o sequence 0,1,2,3,4; state 4 has reg_write=1, wb_sel=01; instr_done_o pulses at cycle 5 only.
- R-type add (op 0, funct 0x20): sequence 0,1,6,7; state 6 alu_op=10. jr (funct 0x08): sequence 0,1,13 with pc_source=11.
- bne (op 0x05): state 8 asserts pc_write_cond=1, branch_ne=1, alu_op=01. beq (0x04): branch_ne=0.
- jal (op 0x03): state 12 asserts reg_dst=10, wb_sel=10, pc_write=1, pc_source=10. Then op 0x3F -> state 14, illegal_o=1, held for 10 cycles; reset recovers to FETCH.
- MEM_WAIT_EN: sw with mem_ready_i low for 3 cycles in state 5 -> mem_write held 4 cycles, instr_done_o pulses once, in the ready cycle. Async reset asserted mid-wait -> all outputs 0 immediately.
